cg_rvarch_decode_stage: RTL and testbench

CG_RVARCH_DECODE_STAGE -- requirements
Module: cg_rvarch_decode_stage

---
 rtl/cg_rvarch_decode_stage.sv | 141 ++++++++++++++
 tb/tb_cg_rvarch_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_rvarch_decode_stage.sv
// RV32I decode stage: combinational field/immediate decode feeding a two-entry
// (output + skid) register pipeline with a registered ready.
module cg_rvarch_decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic [2:0]             o_imm_type,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [2:0]             o_funct3,
    output logic [6:0]             o_funct7,
    output logic                   o_illegal
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            imm_type;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  illegal;
    } entry_t;

    entry_t      dec;
    logic [31:0] imm32;
    entry_t      out_q, out_d, skid_q, skid_d;
    logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic        accept, consume;

    always_comb begin
        dec          = '0;
        imm32        = '0;
        dec.pc       = i_pc;
        dec.rd       = i_instr[11:7];
        dec.rs1      = i_instr[19:15];
        dec.rs2      = i_instr[24:20];
        dec.funct3   = i_instr[14:12];
        dec.funct7   = i_instr[31:25];
        dec.imm_type = IMM_NONE;
        case (i_instr[6:0])
            7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec.imm_type = IMM_I;
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b0100011: begin
                dec.imm_type = IMM_S;
                imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
                dec.imm_type = IMM_B;
                imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.imm_type = IMM_U;
                imm32 = {i_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.imm_type = IMM_J;
                imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            7'b0110011: dec.imm_type = IMM_NONE;
            default:    dec.illegal  = 1'b1;
        endcase
        dec.imm = DATA_WIDTH'($signed(imm32));
    end

    assign o_ready = !skid_vld_q;
    assign accept  = i_valid && o_ready;
    assign consume = out_vld_q && i_ready;

    // The skid only fills when the output register is held; while it is full,
    // o_ready is low so a skid drain never coincides with a new accept.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (consume && skid_vld_q) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
        end else if (consume || !out_vld_q) begin
            out_vld_d = accept;
            if (accept) out_d = dec;
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_valid    = out_vld_q;
    assign o_pc       = out_q.pc;
    assign o_imm      = out_q.imm;
    assign o_imm_type = out_q.imm_type;
    assign o_rd       = out_q.rd;
    assign o_rs1      = out_q.rs1;
    assign o_rs2      = out_q.rs2;
    assign o_funct3   = out_q.funct3;
    assign o_funct7   = out_q.funct7;
    assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_cg_rvarch_decode_stage.sv
// Bench for cg_rvarch_decode_stage: decode reference model plus an in-order
// scoreboard checked on every output handshake, with per-scenario tasks.
module tb_cg_rvarch_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_imm;
    logic [2:0]  o_imm_type;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic        o_illegal;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } ent_t;

    ent_t sb[$];

    cg_rvarch_decode_stage dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_imm(o_imm),
        .o_imm_type(o_imm_type), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    function automatic ent_t model(input logic [31:0] in, input logic [31:0] pc);
        ent_t e;
        e     = '0;
        e.pc  = pc;
        e.rd  = in[11:7];
        e.rs1 = in[19:15];
        e.rs2 = in[24:20];
        e.f3  = in[14:12];
        e.f7  = in[31:25];
        case (in[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: begin e.typ = 3'd1; e.imm = {{20{in[31]}}, in[31:20]}; end
            7'h23: begin e.typ = 3'd2; e.imm = {{20{in[31]}}, in[31:25], in[11:7]}; end
            7'h63: begin e.typ = 3'd3; e.imm = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.typ = 3'd4; e.imm = {in[31:12], 12'h000}; end
            7'h6F: begin e.typ = 3'd5; e.imm = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0}; end
            7'h33: e.typ = 3'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: pop on each output handshake, push on each accepted input.
    always @(negedge i_clk) begin
        ent_t got, exp;
        if (i_reset_n) begin
            if (i_flush) begin
                sb.delete();
            end else begin
                if (o_valid && i_ready) begin
                    got = {o_pc, o_imm, o_imm_type, o_rd, o_rs1, o_rs2, o_funct3, o_funct7, o_illegal};
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected got=%h required=none", got);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL sb_entry got=%h required=%h", got, exp);
                        end
                    end
                end
                if (i_valid && o_ready) sb.push_back(model(i_instr, i_pc));
            end
        end
    end

    task automatic push_item(input logic [31:0] ins, input logic [31:0] pc);
        bit acc;
        acc     = 1'b0;
        i_valid = 1'b1;
        i_instr = ins;
        i_pc    = pc;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=not_accepted required=accepted pc=%h", pc);
        end
    endtask

    task automatic drain();
        bit done;
        done    = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge i_clk);
            #1;
            done = (sb.size() == 0) && !o_valid;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain got=pending%0d required=pending0", sb.size());
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks += 4;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", o_valid); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b required=1", o_ready); end
        if (o_imm !== 32'h0) begin failures++; $display("FAIL rst_imm got=%h required=0", o_imm); end
        if (o_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h required=0", o_pc); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_known(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] typ,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic ill);
        i_ready = 1'b1;
        push_item(ins, 32'h100);
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_imm !== imm || o_imm_type !== typ || o_rd !== rd ||
            o_rs1 !== rs1 || o_illegal !== ill)
        begin
            failures++;
            $display("FAIL known_%h got=v%b imm=%h t=%0d rd=%0d rs1=%0d ill=%b required=v1 imm=%h t=%0d rd=%0d rs1=%0d ill=%b",
                     ins, o_valid, o_imm, o_imm_type, o_rd, o_rs1, o_illegal, imm, typ, rd, rs1, ill);
        end
        drain();
    endtask

    task automatic test_stream();
        logic [31:0] tbl [8];
        tbl = '{32'h00112223, 32'h008000EF, 32'h002081B3, 32'h00001517,
                32'h00000090, 32'h8000006F, 32'hFFF12083, 32'h80000FE3};
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_item(tbl[k], 32'h200 + 32'(4 * k));
        drain();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        push_item(32'h00A00093, 32'h300);
        push_item(32'h00B00113, 32'h304);
        fork
            begin
                push_item(32'h00C00193, 32'h308);
                i_valid = 1'b0;
            end
            begin
                int vcnt;
                repeat (3) @(posedge i_clk);
                #1;
                checks += 2;
                if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b required=0", o_ready); end
                if (o_pc !== 32'h300) begin failures++; $display("FAIL bp_hold_pc got=%h required=300", o_pc); end
                i_ready = 1'b1;
                vcnt = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge i_clk);
                    if (o_valid) vcnt++;
                end
                checks++;
                if (vcnt != 3) begin failures++; $display("FAIL bp_throughput got=%0d required=3", vcnt); end
            end
        join
        drain();
    endtask

    task automatic test_flush();
        int vcnt;
        i_ready = 1'b0;
        push_item(32'h00100093, 32'h400);
        push_item(32'h00200113, 32'h404);
        i_valid = 1'b1;
        i_instr = 32'h00300193;
        i_pc    = 32'h408;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        checks += 2;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b required=0", o_valid); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b required=1", o_ready); end
        i_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin failures++; $display("FAIL flush_delivered got=%0d required=0", vcnt); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        push_item(32'h00500293, 32'h500);
        i_valid = 1'b0;
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        checks += 2;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b required=0", o_valid); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b required=1", o_ready); end
        sb.delete();
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        i_ready   = 1'b1;
        push_item(32'hFFF00093, 32'h600);
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h600) begin
            failures++;
            $display("FAIL rstmid_first got=v%b pc=%h required=v1 pc=600", o_valid, o_pc);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int k = 0; k < 12; k++)
                    push_item({12'(k * 37 - 5), 5'(k), 3'(k), 5'(k + 1), 7'h13} ^ {k[0], 31'h0}, 32'h700 + 32'(4 * k));
                i_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = 1'($urandom_range(0, 1));
                end
                i_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_known(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 5'd1, 5'd0, 1'b0);
        test_known(32'h123452B7, 32'h12345000, 3'd4, 5'd5, 5'd8, 1'b0);
        test_known(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 5'd29, 5'd0, 1'b0);
        test_known(32'h00000000, 32'h00000000, 3'd0, 5'd0, 5'd0, 1'b1);
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
